// File: rtl/pwm_dac_pkg.sv
// Shared constants and helpers for the waveform PWM DAC output stage.
package pwm_dac_pkg;

  localparam int unsigned DEFAULT_SAMPLE_WIDTH = 8;
  localparam int unsigned DEFAULT_PRESCALE     = 1;

  // A PWM period of 2^width-1 counts lets duty 0 and duty 2^width-1 be exact endpoints.
  function automatic int unsigned pwm_period(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/clk_enable_divider.sv
// Clock-enable divider: pulses tick once every PRESCALE enabled clk cycles.
module clk_enable_divider
  import pwm_dac_pkg::*;
#(
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;

  assign tick = en && (pcnt_q == LAST);

  // Disabled divider parks at zero so re-enabling starts a clean count.
  always_comb begin
    pcnt_d = pcnt_q;
    if (!en || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/waveform_pwm_dac.sv
// 1-bit PWM DAC fed by the function generator; duty is double-buffered and swapped only at period wrap.
module waveform_pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_SAMPLE_WIDTH,
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             overrun_clr,
  output logic             pwm_out,
  output logic             period_start,
  output logic             overrun
);

  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(pwm_period(WIDTH) - 1);

  logic             tick;
  logic             wrap;
  logic             accept;
  logic             drop;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             pendingFull_q, pendingFull_d;
  logic             overrun_q, overrun_d;
  logic             pwmOut_q, pwmOut_d;
  logic             periodStart_q, periodStart_d;

  clk_enable_divider #(
    .PRESCALE(PRESCALE)
  ) u_divider (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .tick (tick)
  );

  assign wrap         = tick && (cnt_q == CNT_LAST);
  assign accept       = sample_valid && !pendingFull_q;
  assign drop         = sample_valid && pendingFull_q;
  assign sample_ready = !pendingFull_q;
  assign pwm_out      = pwmOut_q;
  assign period_start = periodStart_q;
  assign overrun      = overrun_q;

  // While disabled the pending sample is pushed straight into duty so enabling uses the latest value.
  always_comb begin
    cnt_d         = cnt_q;
    duty_d        = duty_q;
    pending_d     = pending_q;
    pendingFull_d = pendingFull_q;
    overrun_d     = overrun_q;
    if (!en || wrap) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (pendingFull_q && (!en || wrap)) begin
      duty_d        = pending_q;
      pendingFull_d = 1'b0;
    end
    if (accept) begin
      pending_d     = sample;
      pendingFull_d = 1'b1;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    pwmOut_d      = en && (cnt_q < duty_q);
    periodStart_d = en && wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      duty_q        <= '0;
      pending_q     <= '0;
      pendingFull_q <= 1'b0;
      overrun_q     <= 1'b0;
      pwmOut_q      <= 1'b0;
      periodStart_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      duty_q        <= duty_d;
      pending_q     <= pending_d;
      pendingFull_q <= pendingFull_d;
      overrun_q     <= overrun_d;
      pwmOut_q      <= pwmOut_d;
      periodStart_q <= periodStart_d;
    end
  end

endmodule

// File: tb/tb_waveform_pwm_dac.sv
// Directed bench for waveform_pwm_dac: one PRESCALE=1 instance and one PRESCALE=4 instance.
module tb_waveform_pwm_dac;

  logic       clk;
  logic       reset, en, sample_valid, overrun_clr;
  logic [7:0] sample;
  logic       sample_ready, pwm_out, period_start, overrun;
  logic       reset4, en4, valid4, clr4;
  logic [7:0] sample4;
  logic       ready4, pwm4, ps4, ovr4;

  int testsRun    = 0;
  int testsFailed = 0;

  waveform_pwm_dac #(.WIDTH(8), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .en(en), .sample(sample), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun_clr(overrun_clr), .pwm_out(pwm_out),
    .period_start(period_start), .overrun(overrun)
  );

  waveform_pwm_dac #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset4), .en(en4), .sample(sample4), .sample_valid(valid4),
    .sample_ready(ready4), .overrun_clr(clr4), .pwm_out(pwm4),
    .period_start(ps4), .overrun(ovr4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  // Steps until period_start; step k is expected high when (k-1)/pre < expDuty (valid when started at a period start).
  task automatic runPeriod(input bit four, input int expDuty, input int pre,
                           output int len, output int highs, output int shapeErr);
    bit   seen;
    logic p;
    logic expHigh;
    seen = 1'b0; len = 0; highs = 0; shapeErr = 0;
    for (int k = 1; k <= 1100 * pre && !seen; k++) begin
      tick1();
      p       = four ? pwm4 : pwm_out;
      expHigh = ((k - 1) / pre) < expDuty;
      len     = k;
      if (p === 1'b1) highs++;
      if (p !== expHigh) shapeErr++;
      if ((four ? ps4 : period_start) === 1'b1) seen = 1'b1;
    end
    testsRun++; if (!seen) begin testsFailed++; $display("[TB] FAIL period_timeout: actual no period_start in %0d cycles, required one", len); end
  endtask

  task automatic test_reset();
    int len, highs, se;
    reset = 1'b1;
    repeat (3) begin
      en = 1'($urandom); sample = 8'($urandom); sample_valid = 1'($urandom); overrun_clr = 1'($urandom);
      tick1();
    end
    testsRun++; if (pwm_out !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_pwm: actual %b, required 0", pwm_out); end
    testsRun++; if (period_start !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ps: actual %b, required 0", period_start); end
    testsRun++; if (overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ovr: actual %b, required 0", overrun); end
    testsRun++; if (sample_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready: actual %b, required 1", sample_ready); end
    reset = 1'b0; en = 1'b1; sample_valid = 1'b0; overrun_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      runPeriod(1'b0, 0, 1, len, highs, se);
      testsRun++; if (len !== 255) begin testsFailed++; $display("[TB] FAIL reset_len%0d: actual %0d, required 255", i, len); end
      testsRun++; if (highs !== 0) begin testsFailed++; $display("[TB] FAIL reset_highs%0d: actual %0d, required 0", i, highs); end
    end
  endtask

  task automatic test_endpoints();
    int len, highs, se;
    sample = 8'h00; sample_valid = 1'b1; tick1(); sample_valid = 1'b0;
    testsRun++; if (sample_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL ep_ready_full: actual %b, required 0", sample_ready); end
    runPeriod(1'b0, 0, 1, len, highs, se);
    testsRun++; if (len !== 254) begin testsFailed++; $display("[TB] FAIL ep_rest_len: actual %0d, required 254", len); end
    testsRun++; if (sample_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL ep_ready_free: actual %b, required 1", sample_ready); end
    sample = 8'hFF; sample_valid = 1'b1; tick1(); sample_valid = 1'b0;
    runPeriod(1'b0, 0, 1, len, highs, se);
    testsRun++; if (highs !== 0) begin testsFailed++; $display("[TB] FAIL ep_zero_highs: actual %0d, required 0", highs); end
    for (int i = 0; i < 2; i++) begin
      runPeriod(1'b0, 255, 1, len, highs, se);
      testsRun++; if (highs !== 255) begin testsFailed++; $display("[TB] FAIL ep_full_highs%0d: actual %0d, required 255", i, highs); end
      testsRun++; if (len !== 255) begin testsFailed++; $display("[TB] FAIL ep_full_len%0d: actual %0d, required 255", i, len); end
    end
  endtask

  task automatic test_mid_duty();
    int len, highs, se;
    sample = 8'h40; sample_valid = 1'b1; tick1(); sample_valid = 1'b0;
    runPeriod(1'b0, 0, 1, len, highs, se);
    for (int i = 0; i < 2; i++) begin
      runPeriod(1'b0, 64, 1, len, highs, se);
      testsRun++; if (highs !== 64) begin testsFailed++; $display("[TB] FAIL mid_highs%0d: actual %0d, required 64", i, highs); end
      testsRun++; if (se !== 0) begin testsFailed++; $display("[TB] FAIL mid_shape%0d: actual %0d wrong cycles, required 0", i, se); end
    end
  endtask

  task automatic test_overrun();
    int len, highs, se;
    sample = 8'h80; sample_valid = 1'b1; tick1();
    testsRun++; if (sample_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovr_ready_low: actual %b, required 0", sample_ready); end
    testsRun++; if (overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovr_before: actual %b, required 0", overrun); end
    sample = 8'h20; tick1(); sample_valid = 1'b0;
    testsRun++; if (overrun !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovr_set: actual %b, required 1", overrun); end
    runPeriod(1'b0, 0, 1, len, highs, se);
    testsRun++; if (sample_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovr_ready_back: actual %b, required 1", sample_ready); end
    runPeriod(1'b0, 128, 1, len, highs, se);
    testsRun++; if (highs !== 128) begin testsFailed++; $display("[TB] FAIL ovr_duty_highs: actual %0d, required 128", highs); end
    testsRun++; if (overrun !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovr_sticky: actual %b, required 1", overrun); end
    overrun_clr = 1'b1; tick1(); overrun_clr = 1'b0;
    testsRun++; if (overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovr_clear: actual %b, required 0", overrun); end
    sample = 8'h80; sample_valid = 1'b1; tick1();
    sample = 8'h20; overrun_clr = 1'b1; tick1(); sample_valid = 1'b0; overrun_clr = 1'b0;
    testsRun++; if (overrun !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovr_set_wins: actual %b, required 1", overrun); end
  endtask

  task automatic test_reset_mid();
    int len, highs, se;
    runPeriod(1'b0, 0, 1, len, highs, se);
    repeat (50) tick1();
    testsRun++; if (pwm_out !== 1'b1) begin testsFailed++; $display("[TB] FAIL rm_pre_pwm: actual %b, required 1", pwm_out); end
    reset = 1'b1; tick1();
    testsRun++; if (pwm_out !== 1'b0) begin testsFailed++; $display("[TB] FAIL rm_pwm: actual %b, required 0", pwm_out); end
    testsRun++; if (overrun !== 1'b0) begin testsFailed++; $display("[TB] FAIL rm_ovr: actual %b, required 0", overrun); end
    testsRun++; if (sample_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL rm_ready: actual %b, required 1", sample_ready); end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      runPeriod(1'b0, 0, 1, len, highs, se);
      testsRun++; if (highs !== 0) begin testsFailed++; $display("[TB] FAIL rm_highs%0d: actual %0d, required 0", i, highs); end
      testsRun++; if (len !== 255) begin testsFailed++; $display("[TB] FAIL rm_len%0d: actual %0d, required 255", i, len); end
    end
  endtask

  task automatic test_prescale();
    int len, highs, se;
    reset4 = 1'b0; sample4 = 8'h10; valid4 = 1'b1; tick1(); valid4 = 1'b0;
    testsRun++; if (ready4 !== 1'b0) begin testsFailed++; $display("[TB] FAIL ps_ready_full: actual %b, required 0", ready4); end
    tick1();
    testsRun++; if (ready4 !== 1'b1) begin testsFailed++; $display("[TB] FAIL ps_ready_free: actual %b, required 1", ready4); end
    testsRun++; if (pwm4 !== 1'b0) begin testsFailed++; $display("[TB] FAIL ps_pwm_off: actual %b, required 0", pwm4); end
    en4 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      runPeriod(1'b1, 16, 4, len, highs, se);
      testsRun++; if (len !== 1020) begin testsFailed++; $display("[TB] FAIL ps_len%0d: actual %0d, required 1020", i, len); end
      testsRun++; if (highs !== 64) begin testsFailed++; $display("[TB] FAIL ps_highs%0d: actual %0d, required 64", i, highs); end
      testsRun++; if (se !== 0) begin testsFailed++; $display("[TB] FAIL ps_shape%0d: actual %0d wrong cycles, required 0", i, se); end
    end
    repeat (10) tick1();
    testsRun++; if (pwm4 !== 1'b1) begin testsFailed++; $display("[TB] FAIL ps_pre_drop: actual %b, required 1", pwm4); end
    en4 = 1'b0; tick1();
    testsRun++; if (pwm4 !== 1'b0) begin testsFailed++; $display("[TB] FAIL ps_drop_pwm: actual %b, required 0", pwm4); end
    testsRun++; if (ps4 !== 1'b0) begin testsFailed++; $display("[TB] FAIL ps_drop_ps: actual %b, required 0", ps4); end
    repeat (5) tick1();
    en4 = 1'b1;
    runPeriod(1'b1, 16, 4, len, highs, se);
    testsRun++; if (len !== 1020) begin testsFailed++; $display("[TB] FAIL ps_reen_len: actual %0d, required 1020", len); end
    testsRun++; if (highs !== 64) begin testsFailed++; $display("[TB] FAIL ps_reen_highs: actual %0d, required 64", highs); end
    testsRun++; if (se !== 0) begin testsFailed++; $display("[TB] FAIL ps_reen_shape: actual %0d wrong cycles, required 0", se); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sample = 8'h00; sample_valid = 1'b0; overrun_clr = 1'b0;
    reset4 = 1'b1; en4 = 1'b0; sample4 = 8'h00; valid4 = 1'b0; clr4 = 1'b0;
    test_reset();
    test_endpoints();
    test_mid_duty();
    test_overrun();
    test_reset_mid();
    test_prescale();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/waveform_pwm_dac.md
Name: waveform_pwm_dac

Overview:
- Output stage directly downstream of the function generator.
- Consumes the 8-bit generated waveform samples and produces a single-bit PWM stream that drives an external RC low-pass filter, acting as a 1-bit DAC.
- Samples are double-buffered: a new duty value takes effect only at a PWM period boundary, so no glitched periods occur.
- Upstream overrun is flagged.

Parameters:
- WIDTH, 8, sample width in bits; PWM period is 2^WIDTH-1 counts.
- PRESCALE, 1, clk cycles per PWM count (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  enables PWM generation.
- sample  input  WIDTH  unsigned waveform sample from the function generator.
- sample_valid  input  1  sample is presented this cycle.
- sample_ready  output  1  pending buffer is empty; a sample is accepted when valid&&ready.
- overrun_clr  input  1  clears the sticky overrun flag.
- pwm_out  output  1  registered PWM output.
- period_start  output  1  one-cycle pulse at each PWM period start.
- overrun  output  1  sticky; set when sample_valid is high while sample_ready is low.

Behaviour:
- Reset (synchronous, active-high) has priority over all other inputs and sets:
  - pwm_out=0, period_start=0, overrun=0.
  - sample_ready=1 (pending empty).
  - duty=0, cnt=0, prescale counter=0.
- Prescaler:
  - pcnt runs 0..PRESCALE-1 while en=1.
  - tick=1 when pcnt==PRESCALE-1, then pcnt wraps to 0.
  - With PRESCALE=1, tick=1 every cycle.
- PWM counter:
  - cnt runs 0..2^WIDTH-2 and advances on tick.
  - At cnt==2^WIDTH-2 with tick, cnt wraps to 0 (wrap event).
- Registered output: pwm_out <= en && (cnt < duty), using current register values. This gives one cycle of latency from cnt to pin.
- Duty endpoints are exact:
  - duty=0: pwm_out is always low.
  - duty=2^WIDTH-1: pwm_out is always high.
- period_start <= en && wrap event; it is a one-cycle pulse coinciding with cnt becoming 0.
- Input buffer:
  - Consists of one pending register plus a pending_full flag; sample_ready = !pending_full, combinational from the flag.
  - Accept (sample_valid && sample_ready): pending <= sample, pending_full <= 1.
  - Wrap event with pending_full=1: duty <= pending, pending_full <= 0. sample_ready rises the following cycle.
  - Accept in the same cycle as a wrap with the buffer empty: the sample goes to pending and is applied at the next wrap. There is no bypass.
  - sample_valid while sample_ready=0: the sample is dropped and overrun <= 1.
- overrun_clr:
  - overrun_clr=1 clears overrun.
  - If a new drop occurs in the same cycle as the clear, the set wins.
- en=0:
  - pcnt and cnt are held at 0.
  - pwm_out=0, period_start=0.
  - If pending_full=1, duty <= pending each cycle and the buffer is freed, so the latest sample is used when enabling.
- en rising:
  - The first period starts at cnt=0.
  - No period_start pulse is issued for that first period.
- Reset asserted mid-period aborts the period; the next edge gives the reset values.
- Widths: all compares are unsigned WIDTH-bit; pcnt width is clog2(PRESCALE), with a minimum of 1 bit.

Decomposition:
- Shared package pwm_dac_pkg holds:
  - Constants DEFAULT_SAMPLE_WIDTH=8 and DEFAULT_PRESCALE=1.
  - A function pwm_period(width) returning 2^width-1.
- One natural sub-module, clk_enable_divider (PRESCALE parameter; ports clk, reset, en; output tick). It is reusable for the generator's frequency stepping.
- The duty buffer and PWM counter stay in the top module.

Test Plan (WIDTH=8 unless noted):
1. Reset: hold reset for 3 cycles with random inputs -> pwm_out=0, period_start=0, overrun=0, sample_ready=1. Release with en=1 -> period_start pulses every 255 cycles and pwm_out stays low (duty 0).
2. Endpoints: accept sample 0x00, then after the next wrap accept 0xFF -> 0x00 period has 0 high cycles; from the following wrap, pwm_out is high all 255 cycles of every period.
3. Mid duty: accept 0x40 -> starting one cycle after the next period_start, pwm_out is high for exactly 64 cycles and low for 191, repeating.
4. Backpressure/overrun: accept 0x80, present 0x20 before the wrap -> sample_ready=0, 0x20 dropped, overrun=1. At the wrap, duty=0x80 and sample_ready=1 next cycle. overrun_clr -> overrun=0.
5. Reset mid-operation: with duty 0x80, assert reset at cnt=50 -> next edge pwm_out=0 and duty=0. After release, low periods until a new sample is applied.
6. PRESCALE=4, sample 0x10: period_start every 1020 cycles, pwm_out high for 64 cycles per period. Drop en mid-period -> pwm_out=0 next cycle. Re-enable -> a full new period from cnt=0.
